// File: rtl/uart_rx_buffered_if.sv
// Receive-side handshake bundle for uart_rx_buffered.
// The receiver drives the byte, status and error pulses; the consumer drives the ack.
interface uart_rx_buffered_if;
    logic       dout_ack;
    logic [7:0] dout;
    logic       dout_vld;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    modport master (
        input  dout_ack,
        output dout,
        output dout_vld,
        output parity_err,
        output frame_err,
        output overrun,
        output busy
    );

    modport slave (
        output dout_ack,
        input  dout,
        input  dout_vld,
        input  parity_err,
        input  frame_err,
        input  overrun,
        input  busy
    );
endinterface

// File: rtl/uart_rx_buffered.sv
// UART receiver: 2-flop sync, bit-timed sampling FSM, parity/framing checks,
// and a one-entry holding register with valid/ack handshake and overrun flag.
module uart_rx_buffered #(
    parameter int CLK_FREQ     = 10_000_000,
    parameter int BAUD_RATE    = 115200,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE,
    parameter int CHECK_SEL    = 1
) (
    input  logic CLK,
    input  logic rst_n,
    input  logic RX,
    uart_rx_buffered_if.master rx_if
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
    localparam logic [2:0] PARITY    = 3'd3;
    localparam logic [2:0] STOP      = 3'd4;
    localparam logic [2:0] WAIT_HIGH = 3'd5;

    logic          rx_q1;
    logic          rx_s;
    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_end;
    logic          tick;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          par_bad;
    logic          par_x;
    logic          done;
    logic          stop_bad;

    logic [7:0]    dout_q;
    logic          vld_q;
    logic          perr_q;
    logic          ferr_q;
    logic          ovr_q;

    // Two-flop synchronizer; idles high so reset never looks like a start bit
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            rx_q1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            rx_q1 <= RX;
            rx_s  <= rx_q1;
        end
    end

    // Sample point: half a bit in START, a full bit elsewhere
    always_comb begin
        cnt_end  = (state == START) ? HALF_END : BIT_END;
        tick     = (cnt == cnt_end);
        par_x    = (^shift) ^ rx_s;
        done     = (state == STOP) && tick && rx_s;
        stop_bad = (state == STOP) && tick && !rx_s;
    end

    // Frame FSM: walks start, data, optional parity and stop bits
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            par_bad <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rx_s) begin
                        state   <= START;
                        par_bad <= 1'b0;
                    end
                end
                START: begin
                    cnt <= tick ? '0 : cnt + 1'b1;
                    if (tick) begin
                        state   <= rx_s ? IDLE : DATA;
                        bit_idx <= '0;
                    end
                end
                DATA: begin
                    cnt <= tick ? '0 : cnt + 1'b1;
                    if (tick) begin
                        shift   <= {rx_s, shift[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7)
                            state <= (CHECK_SEL != 0) ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    cnt <= tick ? '0 : cnt + 1'b1;
                    if (tick) begin
                        par_bad <= (CHECK_SEL == 2) ? par_x : ~par_x;
                        state   <= STOP;
                    end
                end
                STOP: begin
                    cnt <= tick ? '0 : cnt + 1'b1;
                    if (tick)
                        state <= rx_s ? IDLE : WAIT_HIGH;
                end
                WAIT_HIGH: begin
                    cnt <= '0;
                    if (rx_s)
                        state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Holding register: a completing frame beats a same-cycle ack
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= '0;
            vld_q  <= 1'b0;
            perr_q <= 1'b0;
            ferr_q <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            perr_q <= 1'b0;
            ovr_q  <= 1'b0;
            ferr_q <= stop_bad;
            if (done) begin
                if (!vld_q || rx_if.dout_ack) begin
                    dout_q <= shift;
                    vld_q  <= 1'b1;
                    perr_q <= par_bad;
                end else begin
                    ovr_q <= 1'b1;
                end
            end else if (vld_q && rx_if.dout_ack) begin
                vld_q <= 1'b0;
            end
        end
    end

    assign rx_if.dout       = dout_q;
    assign rx_if.dout_vld   = vld_q;
    assign rx_if.parity_err = perr_q;
    assign rx_if.frame_err  = ferr_q;
    assign rx_if.overrun    = ovr_q;
    assign rx_if.busy       = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Directed bench for uart_rx_buffered: odd-parity DUT under test plus an
// even-parity DUT with a permanently asserted ack for the parity-mode check.
module tb_uart_rx_buffered;

    localparam int CPB = 86;

    logic CLK = 1'b0;
    logic rst_n;
    logic RX;

    int errors = 0;
    int checks = 0;

    int pe_n = 0, fe_n = 0, ov_n = 0, both_n = 0;
    int vhi_n = 0, vlo_n = 0, p2_n = 0;
    logic [7:0] d2 = 8'h00;

    int b_pe, b_fe, b_ov, b_vhi, b_vlo, b_p2;

    always #5 CLK = ~CLK;

    uart_rx_buffered_if rx_if ();
    uart_rx_buffered_if rx_if2 ();

    assign rx_if2.dout_ack = 1'b1;

    uart_rx_buffered #(
        .CLK_FREQ (10_000_000),
        .BAUD_RATE(115200),
        .CHECK_SEL(1)
    ) dut (
        .CLK  (CLK),
        .rst_n(rst_n),
        .RX   (RX),
        .rx_if(rx_if)
    );

    uart_rx_buffered #(
        .CLK_FREQ (10_000_000),
        .BAUD_RATE(115200),
        .CHECK_SEL(2)
    ) dut2 (
        .CLK  (CLK),
        .rst_n(rst_n),
        .RX   (RX),
        .rx_if(rx_if2)
    );

    // Pulse and level monitors, sampled away from the active edge
    always @(negedge CLK) begin
        pe_n  += int'(rx_if.parity_err);
        fe_n  += int'(rx_if.frame_err);
        ov_n  += int'(rx_if.overrun);
        if (int'(rx_if.parity_err) + int'(rx_if.frame_err)
            + int'(rx_if.overrun) > 1)
            both_n++;
        if (rx_if.dout_vld) vhi_n++;
        else vlo_n++;
        p2_n += int'(rx_if2.parity_err);
        if (rx_if2.dout_vld) d2 = rx_if2.dout;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        b_pe  = pe_n;
        b_fe  = fe_n;
        b_ov  = ov_n;
        b_vhi = vhi_n;
        b_vlo = vlo_n;
        b_p2  = p2_n;
    endtask

    // One frame: start, 8 data LSB first, parity, stop; optional ack pulse
    // at negedge ack_at counted from the start-bit edge
    task automatic send_frame(input logic [7:0] d, input logic p,
                              input logic stp, input int ack_at);
        logic [10:0] fb;
        int n;
        fb = {stp, p, d, 1'b0};
        n = 0;
        @(negedge CLK);
        for (int i = 0; i < 11; i++) begin
            RX = fb[i];
            for (int j = 0; j < CPB; j++) begin
                @(negedge CLK);
                n++;
                if (ack_at != 0) rx_if.dout_ack = (n == ack_at);
            end
        end
        RX = 1'b1;
    endtask

    task automatic ack_pulse();
        @(negedge CLK);
        rx_if.dout_ack = 1'b1;
        @(negedge CLK);
        rx_if.dout_ack = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        RX = 1'b1;
        rx_if.dout_ack = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_dout", 32'(rx_if.dout), 32'h0);
        chk("rst_vld", 32'(rx_if.dout_vld), 32'h0);
        chk("rst_perr", 32'(rx_if.parity_err), 32'h0);
        chk("rst_ferr", 32'(rx_if.frame_err), 32'h0);
        chk("rst_ovr", 32'(rx_if.overrun), 32'h0);
        chk("rst_busy", 32'(rx_if.busy), 32'h0);
        rst_n = 1'b1;
        repeat (5) @(negedge CLK);

        // A5 with correct odd parity, no ack
        snap();
        send_frame(8'hA5, 1'b1, 1'b1, 0);
        chk("a5_dout", 32'(rx_if.dout), 32'hA5);
        chk("a5_vld", 32'(rx_if.dout_vld), 32'h1);
        chk("a5_perr", 32'(pe_n - b_pe), 32'h0);
        chk("a5_ferr", 32'(fe_n - b_fe), 32'h0);
        chk("even_err_on_p1", 32'(p2_n - b_p2), 32'h1);
        chk("even_dout", 32'(d2), 32'hA5);
        repeat (10) @(negedge CLK);
        chk("a5_vld_held", 32'(rx_if.dout_vld), 32'h1);
        ack_pulse();
        chk("a5_vld_clr", 32'(rx_if.dout_vld), 32'h0);

        // A5 with wrong odd parity: loaded, one-cycle parity_err
        snap();
        send_frame(8'hA5, 1'b0, 1'b1, 0);
        chk("bad_dout", 32'(rx_if.dout), 32'hA5);
        chk("bad_vld", 32'(rx_if.dout_vld), 32'h1);
        chk("bad_perr_1cyc", 32'(pe_n - b_pe), 32'h1);
        chk("even_ok_on_p0", 32'(p2_n - b_p2), 32'h0);
        ack_pulse();

        // Glitch: 20 cycles low
        snap();
        @(negedge CLK);
        RX = 1'b0;
        repeat (20) @(negedge CLK);
        RX = 1'b1;
        repeat (45) @(negedge CLK);
        chk("glitch_busy", 32'(rx_if.busy), 32'h0);
        chk("glitch_vld", 32'(vhi_n - b_vhi), 32'h0);
        chk("glitch_errs", 32'((pe_n - b_pe) + (fe_n - b_fe)
                               + (ov_n - b_ov)), 32'h0);

        // Break: 12 bit times low
        snap();
        RX = 1'b0;
        repeat (12 * CPB) @(negedge CLK);
        chk("brk_ferr", 32'(fe_n - b_fe), 32'h1);
        chk("brk_perr", 32'(pe_n - b_pe), 32'h0);
        chk("brk_vld", 32'(vhi_n - b_vhi), 32'h0);
        chk("brk_busy", 32'(rx_if.busy), 32'h1);
        RX = 1'b1;
        repeat (6) @(negedge CLK);
        chk("brk_idle", 32'(rx_if.busy), 32'h0);
        snap();
        send_frame(8'h3C, 1'b1, 1'b1, 0);
        chk("3c_dout", 32'(rx_if.dout), 32'h3C);
        chk("3c_errs", 32'((pe_n - b_pe) + (fe_n - b_fe)), 32'h0);
        ack_pulse();

        // Back-to-back 11, 22 without ack -> overrun on the second
        snap();
        send_frame(8'h11, 1'b1, 1'b1, 0);
        chk("11_dout", 32'(rx_if.dout), 32'h11);
        chk("11_ovr", 32'(ov_n - b_ov), 32'h0);
        send_frame(8'h22, 1'b1, 1'b1, 0);
        chk("22_dout_kept", 32'(rx_if.dout), 32'h11);
        chk("22_ovr", 32'(ov_n - b_ov), 32'h1);
        chk("22_vld", 32'(rx_if.dout_vld), 32'h1);
        ack_pulse();
        send_frame(8'h33, 1'b1, 1'b1, 0);
        chk("33_dout", 32'(rx_if.dout), 32'h33);
        chk("33_ovr", 32'(ov_n - b_ov), 32'h1);
        ack_pulse();

        // Reset during data bit 4 of FF
        @(negedge CLK);
        RX = 1'b0;
        repeat (CPB) @(negedge CLK);
        RX = 1'b1;
        repeat (4 * CPB + 40) @(negedge CLK);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_dout", 32'(rx_if.dout), 32'h0);
        chk("mid_rst_vld", 32'(rx_if.dout_vld), 32'h0);
        chk("mid_rst_busy", 32'(rx_if.busy), 32'h0);
        @(negedge CLK);
        rst_n = 1'b1;
        repeat (20) @(negedge CLK);
        snap();
        send_frame(8'h5A, 1'b1, 1'b1, 0);
        chk("5a_dout", 32'(rx_if.dout), 32'h5A);
        chk("5a_errs", 32'((pe_n - b_pe) + (fe_n - b_fe)
                           + (ov_n - b_ov)), 32'h0);
        chk("5a_vld", 32'(rx_if.dout_vld), 32'h1);

        // Ack lands exactly on the completion edge of C3: load wins
        snap();
        send_frame(8'hC3, 1'b1, 1'b1, 905);
        chk("c3_dout", 32'(rx_if.dout), 32'hC3);
        chk("c3_vld", 32'(rx_if.dout_vld), 32'h1);
        chk("c3_vld_never_low", 32'(vlo_n - b_vlo), 32'h0);
        chk("c3_ovr", 32'(ov_n - b_ov), 32'h0);
        chk("c3_perr", 32'(pe_n - b_pe), 32'h0);
        ack_pulse();
        chk("c3_vld_clr", 32'(rx_if.dout_vld), 32'h0);

        chk("no_coincident_pulses", 32'(both_n), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_buffered.md
Name: uart_rx_buffered

Overview:
- Serial UART receiver. It is the receive-side counterpart of the team's UART transmitter and uses the same frame format and parity selection.
- Frame format: 1 start bit, 8 data bits LSB first, optional parity bit, 1 stop bit.
- Oversamples with a per-bit clock counter, checks framing and parity, and holds each received byte in a one-entry output register with a valid/ack handshake and overrun detection.
- Sits between the RX pad and the consumer logic inside the UART top level.

Parameters:
- CLK_FREQ, 10_000_000: system clock frequency in Hz.
- BAUD_RATE, 115200: receive baud rate.
- CLKS_PER_BIT, CLK_FREQ/BAUD_RATE: clocks per bit (86 at defaults). Must be >= 4.
- CHECK_SEL, 1: parity mode. 0 = no parity bit; 1 = odd; 2 = even.

Ports:
- CLK  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- RX  input  1  asynchronous serial line, idles high.
- dout_ack  input  1  consumer accepts the held byte.
- dout  output  8  received byte.
- dout_vld  output  1  dout holds an unaccepted byte.
- parity_err  output  1  one-cycle pulse: the byte being loaded failed parity.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: a frame completed while the holding register was full; that frame is dropped.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - dout=0, dout_vld=0, parity_err=0, frame_err=0, overrun=0, busy=0.
  - State=IDLE; counters and shift register cleared.
  - Synchronizer flops reset to 1.
  - Reset in mid-frame abandons the frame with no error pulse.
- Synchronizer: RX passes through 2 flops. All decisions use the synchronized value rx_s.
- Counter: width $clog2(CLKS_PER_BIT).
- FSM states and transitions:
  - IDLE: rx_s=0 -> START, clear counter.
  - START: count to CLKS_PER_BIT/2-1, then sample. rx_s=1 -> IDLE (glitch, no outputs). rx_s=0 -> DATA, clear counter and bit index.
  - DATA: count to CLKS_PER_BIT-1, then sample rx_s. The sample shifts into bit 7 while the register shifts right, so data lands LSB first. After 8 samples -> PARITY if CHECK_SEL!=0, else STOP.
  - PARITY: count to CLKS_PER_BIT-1, then sample the parity bit.
    - Odd mode: error when XOR of the 8 data bits and the parity bit = 0.
    - Even mode: error when that XOR = 1.
    - -> STOP.
  - STOP: count to CLKS_PER_BIT-1, then sample. rx_s=1 -> completion, then IDLE. rx_s=0 -> frame_err pulse, no load, -> WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s=1, then IDLE. This covers a break condition and prevents retriggering.
- Completion (cycle after the stop sample, registered outputs):
  - dout_vld=0, or dout_ack=1 in the same cycle: dout<=shift, dout_vld<=1, parity_err pulses if the parity check failed.
  - Frames with bad parity are still loaded.
  - dout_vld=1 and dout_ack=0: dout unchanged, overrun pulses, new byte and its parity result discarded.
- Handshake:
  - dout_vld stays high until a cycle with dout_ack=1, then clears the next cycle.
  - If a load happens in the same cycle as the ack, the load wins: dout_vld stays 1 with the new byte.
  - dout_ack while dout_vld=0 is ignored.
- Timing: return to IDLE happens mid-stop-bit, so back-to-back frames with a 1-bit stop are received without gaps.
- Error pulses are exactly one cycle wide and never assert together in the same cycle.

Test Plan:
- Defaults (CHECK_SEL=1, CLKS_PER_BIT=86), send 0xA5 with parity bit 1, no ack -> after the stop sample: dout=0xA5, dout_vld=1 held, parity_err=0, frame_err=0. Assert dout_ack for 1 cycle -> dout_vld=0 the next cycle.
- Same frame with parity bit 0 -> dout=0xA5, dout_vld=1, parity_err high for exactly 1 cycle. With CHECK_SEL=2, parity bit 0 -> no error.
- RX low for 20 cycles then high -> returns to IDLE; no dout_vld and no error pulses; busy drops within 45 cycles.
- RX held low for 12 bit times -> one frame_err pulse, dout_vld stays 0, busy stays high until RX rises. Then 0x3C sent -> dout=0x3C.
- Frames 0x11 then 0x22 back-to-back with no ack -> dout=0x11 throughout, overrun pulses once at the second completion. Ack, then send 0x33 -> dout=0x33.
- rst_n pulsed low during data bit 4 of 0xFF -> all outputs 0 immediately. Then 0x5A sent -> dout=0x5A, no errors.
- Ack asserted in the exact completion cycle of a second frame -> dout shows the new byte, dout_vld never drops, no overrun.
